// File: rtl/alu_mul_sequencer.sv
// Multi-cycle RV64 MUL controller: shift-and-add, one ADD on the shared integer ALU per cycle.
// Optional build macro ALU_MUL_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are zero.
module alu_mul_sequencer #(
  parameter int         WIDTH   = 64,
  parameter logic [3:0] ADD_OP  = 4'b0010,
  parameter logic [3:0] IDLE_OP = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [3:0]       alu_control_signal,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken only in IDLE (busy=0); busy stays high through RUN and DONE,
  // and done is a single-cycle pulse during which product is valid. start while busy is dropped.

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               early_term;
  logic               last_iter;

`ifdef ALU_MUL_EARLY_EXIT_EN
  // Only the bit consumed this cycle can still be set, so nothing is left to add afterwards.
  assign early_term = (mplier[WIDTH-1:1] == '0);
`else
  assign early_term = 1'b0;
`endif

  assign state_dbg = state;

  always_comb begin
    state_next         = state;
    busy               = 1'b0;
    done               = 1'b0;
    alu_input1         = '0;
    alu_input2         = '0;
    alu_control_signal = IDLE_OP;
    acc_next           = mplier[0] ? alu_result : acc;
    last_iter          = (cnt == LAST_CNT) || early_term;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        busy               = 1'b1;
        alu_input1         = acc;
        alu_input2         = mcand;
        alu_control_signal = ADD_OP;
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand   <= multiplicand;
            mplier  <= multiplier;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
          end
        end
        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          // The final partial sum goes straight to product so it is valid during DONE.
          if (last_iter) product <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: vector table, corner sequences, random pairs.
// Build with +define+ALU_MUL_EARLY_EXIT_EN to exercise the early-exit variant.
module tb_alu_mul_sequencer;

  localparam int         W       = 64;
  localparam logic [3:0] ADD_OP  = 4'b0010;
  localparam logic [3:0] IDLE_OP = 4'b0000;
  localparam int         MAX_EDGES = 80;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product;
  logic [W-1:0] alu_input1;
  logic [W-1:0] alu_input2;
  logic [3:0]   alu_control_signal;
  logic [W-1:0] alu_result;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_p;
  } vec_t;
  vec_t vecs[8];

  alu_mul_sequencer #(.WIDTH(W), .ADD_OP(ADD_OP), .IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product),
    .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_control_signal(alu_control_signal), .alu_result(alu_result),
    .state_dbg(state_dbg)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // Shared integer ALU: ADD and AND are all this block drives.
  always_comb begin
    alu_result = '0;
    case (alu_control_signal)
      ADD_OP:  alu_result = alu_input1 + alu_input2;
      IDLE_OP: alu_result = alu_input1 & alu_input2;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // ---- reference model ----
  function automatic logic [W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    p = a * b;
    return p;
  endfunction

  function automatic int ref_runs(input logic [W-1:0] b);
    int n;
`ifdef ALU_MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`else
    n = W;
`endif
    return n;
  endfunction

  // ---- scoreboard: every done pulse pops one expected product ----
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("sb_product", product, exp_q.pop_front());
    end
  end

  // ---- driver ----
  // Called in an IDLE cycle, 1 time unit after an edge. edges counts the accepting edge as 1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit chk_alu,
                        input int inject_at, output logic [W-1:0] p, output int edges);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    exp_q.push_back(ref_product(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    check("cleared_on_accept", product, '0);
    while (!done && edges < MAX_EDGES) begin
      if (chk_alu) begin
        check("run_ctrl", {60'd0, alu_control_signal}, {60'd0, ADD_OP});
        check("run_in2", alu_input2, a << (edges - 1));
        check("run_busy", {63'd0, busy}, 64'd1);
      end
      start = (edges == inject_at);
      if (start) begin
        multiplicand = 64'd9;
        multiplier   = 64'd9;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
    check("done_busy", {63'd0, busy}, 64'd1);
    check("done_ctrl", {60'd0, alu_control_signal}, {60'd0, IDLE_OP});
    check("done_in1", alu_input1, '0);
    p = product;
    @(posedge clk); #1;
    check("pulse_end_done", {63'd0, done}, 64'd0);
    check("pulse_end_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] p;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int edges;

    vecs[0] = '{64'd3, 64'd5, 64'd15};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vecs[3] = '{64'h1234, 64'd0, 64'd0};
    vecs[4] = '{64'd7, 64'd6, 64'd42};
    vecs[5] = '{64'h1234_5678, 64'h10, 64'h1_2345_6780};
    vecs[6] = '{64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vecs[7] = '{64'd2, 64'h8000_0000_0000_0000, 64'd0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, '0);
    check("rst_ctrl", {60'd0, alu_control_signal}, {60'd0, IDLE_OP});
    check("rst_in1", alu_input1, '0);
    check("rst_in2", alu_input2, '0);

    // Table vectors, issued back to back in the first IDLE after each DONE.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b1, -1, p, edges);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp_p);
      check($sformatf("vec%0d_latency", i), 64'(edges), 64'(ref_runs(vecs[i].b) + 1));
    end
    repeat (3) @(posedge clk);
    #1 check("product_held", product, vecs[7].exp_p);

    // start pulsed mid-RUN with other operands must be ignored.
    a = 64'hFF;
    b = 64'h8000_0000_0000_0001;
    run_op(a, b, 1'b0, 3, p, edges);
    check("ignore_start_product", p, 64'h8000_0000_0000_00FF);
    check("ignore_start_idle", {63'd0, busy}, 64'd0);

    // Reset for one edge in RUN cycle 10, then a fresh operation.
    multiplicand = 64'd3;
    multiplier   = 64'h8000_0000_0000_0005;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_product", product, '0);
    check("mid_rst_ctrl", {60'd0, alu_control_signal}, {60'd0, IDLE_OP});
    run_op(64'd7, 64'd6, 1'b0, -1, p, edges);
    check("after_rst_product", p, 64'd42);

    // Random operands with a spread of multiplier magnitudes.
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = {$urandom, $urandom};
        1:       b = {$urandom, $urandom} >> $urandom_range(0, 63);
        2:       b = 64'($urandom_range(0, 3));
        default: b = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      endcase
      run_op(a, b, 1'b0, -1, p, edges);
      check("rand_product", p, ref_product(a, b));
      check("rand_latency", 64'(edges), 64'(ref_runs(b) + 1));
    end

    repeat (2) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
